// File: rtl/i3c_dat_mem_arbiter.sv
// i3c_dat_mem_arbiter: round-robin sharing of the DAT memory port with in-order read-response routing
package i3c_pkg;
  typedef struct packed {
    logic        req;
    logic        write;
    logic [6:0]  addr;
    logic [63:0] wdata;
    logic [63:0] wmask;
  } dat_mem_sink_t;
  typedef struct packed {
    logic        rvalid;
    logic [63:0] rdata;
    logic [1:0]  rerror;
  } dat_mem_src_t;
endpackage

module i3c_dat_mem_arbiter #(
  parameter int NumReq   = 2,
  parameter int MaxOutRd = 2
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  i3c_pkg::dat_mem_sink_t [NumReq-1:0] req_sink_i,
  output logic [NumReq-1:0]                    req_gnt_o,
  output logic [NumReq-1:0]                    req_rvalid_o,
  output logic [63:0]                          req_rdata_o,
  output logic [1:0]                           req_rerror_o,
  output i3c_pkg::dat_mem_sink_t               mem_sink_o,
  input  i3c_pkg::dat_mem_src_t                mem_src_i,
  output logic                                 tag_err_o
);
  localparam int IW = NumReq > 1 ? $clog2(NumReq) : 1;
  localparam int PW = MaxOutRd > 1 ? $clog2(MaxOutRd) : 1;
  localparam int CW = $clog2(MaxOutRd + 1);
  logic [IW-1:0] rr_q, win, idx, head;
  logic [IW-1:0] tag_q [MaxOutRd];
  logic [PW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q;
  logic found, pop, push, can_rd;
  logic [NumReq-1:0] req_vec;
  assign pop    = mem_src_i.rvalid && cnt_q != '0;
  // a response leaving the FIFO this cycle frees its slot for a new read right away
  assign can_rd = cnt_q < CW'(MaxOutRd) || pop;
  assign head   = tag_q[rp_q];
  always_comb begin
    found   = 1'b0;
    win     = '0;
    idx     = '0;
    req_vec = '0;
    for (int k = 0; k < NumReq; k++) begin
      req_vec[k] = req_sink_i[k].req;
      idx = IW'((int'(rr_q) + k) % NumReq);
      if (!found && req_sink_i[idx].req && (req_sink_i[idx].write || can_rd)) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end
  assign push         = found && !req_sink_i[win].write;
  assign req_gnt_o    = found ? NumReq'(1) << win : '0;
  assign req_rvalid_o = pop ? NumReq'(1) << head : '0;
  assign req_rdata_o  = mem_src_i.rdata;
  assign req_rerror_o = mem_src_i.rerror;
  assign mem_sink_o   = found ? req_sink_i[win] : '0;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q      <= '0;
      wp_q      <= '0;
      rp_q      <= '0;
      cnt_q     <= '0;
      tag_err_o <= 1'b0;
    end else begin
      if (found) rr_q <= win == IW'(NumReq - 1) ? '0 : win + 1'b1;
      if (push) begin
        tag_q[wp_q] <= win;
        wp_q        <= wp_q == PW'(MaxOutRd - 1) ? '0 : wp_q + 1'b1;
      end
      if (pop) rp_q <= rp_q == PW'(MaxOutRd - 1) ? '0 : rp_q + 1'b1;
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
      if (mem_src_i.rvalid && cnt_q == '0) tag_err_o <= 1'b1;
    end
  end
  a_gnt_onehot: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(req_gnt_o));
  a_gnt_req:    assert property (@(posedge clk_i) disable iff (rst_i) (req_gnt_o & ~req_vec) == '0);
  a_cnt_max:    assert property (@(posedge clk_i) disable iff (rst_i) cnt_q <= CW'(MaxOutRd));
  a_no_ovf:     assert property (@(posedge clk_i) disable iff (rst_i) !(push && !pop && cnt_q == CW'(MaxOutRd)));
endmodule
